// File: rtl/vx_icache_stage_mo.sv
// Multi-outstanding instruction-fetch stage: tags each fetch with a metadata
// table entry so I-cache responses may return out of order, limits in-flight
// fetches per warp, and optionally registers the response toward decode.
module vx_icache_stage_mo #(
    parameter int unsigned CORE_ID     = 0,
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned TAG_DEPTH   = 8,
    parameter int unsigned MAX_PENDING = 2,
    parameter int unsigned OUT_REG     = 1,
    localparam int unsigned NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int unsigned TAG_BITS   = $clog2(TAG_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ifetch_req_valid,
    input  logic [NW_BITS-1:0]     ifetch_req_wid,
    input  logic [31:0]            ifetch_req_PC,
    input  logic [NUM_THREADS-1:0] ifetch_req_tmask,
    output logic                   ifetch_req_ready,
    output logic                   icache_req_valid,
    output logic [29:0]            icache_req_addr,
    output logic [TAG_BITS-1:0]    icache_req_tag,
    input  logic                   icache_req_ready,
    input  logic                   icache_rsp_valid,
    input  logic [31:0]            icache_rsp_data,
    input  logic [TAG_BITS-1:0]    icache_rsp_tag,
    output logic                   icache_rsp_ready,
    output logic                   ifetch_rsp_valid,
    output logic [NW_BITS-1:0]     ifetch_rsp_wid,
    output logic [31:0]            ifetch_rsp_PC,
    output logic [NUM_THREADS-1:0] ifetch_rsp_tmask,
    output logic [31:0]            ifetch_rsp_instr,
    input  logic                   ifetch_rsp_ready,
    output logic [NUM_WARPS-1:0]   pending_warps,
    output logic                   busy
);

    localparam int unsigned CNT_BITS = $clog2(MAX_PENDING + 1);

    logic [TAG_DEPTH-1:0]   free_mask;
    logic [NW_BITS-1:0]     meta_wid   [TAG_DEPTH];
    logic [31:0]            meta_pc    [TAG_DEPTH];
    logic [NUM_THREADS-1:0] meta_tmask [TAG_DEPTH];
    logic [CNT_BITS-1:0]    cnt        [NUM_WARPS];

    logic [TAG_BITS-1:0]    alloc_idx;
    logic                   can_issue;
    logic                   req_fire;
    logic                   rsp_hit;
    logic                   rsp_ready_int;
    logic                   rsp_take;
    logic                   out_busy;
    logic [NW_BITS-1:0]     rd_wid;
    logic [31:0]            rd_pc;
    logic [NUM_THREADS-1:0] rd_tmask;
    logic [NUM_WARPS-1:0]   cnt_inc;
    logic [NUM_WARPS-1:0]   cnt_dec;

    // Lowest free entry is the next allocation.
    always_comb begin
        alloc_idx = '0;
        for (int i = TAG_DEPTH - 1; i >= 0; i--) begin
            if (free_mask[i]) alloc_idx = TAG_BITS'(i);
        end
    end

    assign can_issue        = (|free_mask) && (cnt[ifetch_req_wid] < CNT_BITS'(MAX_PENDING));
    assign icache_req_valid = ifetch_req_valid && can_issue;
    assign ifetch_req_ready = icache_req_ready && can_issue;
    assign icache_req_addr  = ifetch_req_PC[31:2];
    assign icache_req_tag   = alloc_idx;
    assign req_fire         = ifetch_req_valid && ifetch_req_ready;

    // Response-side table lookup; stale tags are always consumed.
    assign rd_wid           = meta_wid[icache_rsp_tag];
    assign rd_pc            = meta_pc[icache_rsp_tag];
    assign rd_tmask         = meta_tmask[icache_rsp_tag];
    assign rsp_hit          = !free_mask[icache_rsp_tag];
    assign icache_rsp_ready = rsp_ready_int || !rsp_hit;
    assign rsp_take         = icache_rsp_valid && rsp_hit && rsp_ready_int;

    // Per-warp increment/decrement strobes.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_inc[w] = req_fire && (ifetch_req_wid == NW_BITS'(w));
            cnt_dec[w] = rsp_take && (rd_wid == NW_BITS'(w));
        end
    end

    // Entry allocation/free bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_mask <= '1;
        end else begin
            if (req_fire) free_mask[alloc_idx] <= 1'b0;
            if (rsp_take) free_mask[icache_rsp_tag] <= 1'b1;
        end
    end

    // Metadata capture on request fire.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            meta_wid[alloc_idx]   <= ifetch_req_wid;
            meta_pc[alloc_idx]    <= ifetch_req_PC;
            meta_tmask[alloc_idx] <= ifetch_req_tmask;
        end
    end

    // Per-warp outstanding counters; simultaneous inc/dec cancel.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (reset) begin
                cnt[w] <= '0;
            end else if (cnt_inc[w] && !cnt_dec[w]) begin
                cnt[w] <= cnt[w] + CNT_BITS'(1);
            end else if (cnt_dec[w] && !cnt_inc[w]) begin
                cnt[w] <= cnt[w] - CNT_BITS'(1);
            end
        end
    end

    // Pending status straight from the counter registers.
    always_comb begin
        pending_warps = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending_warps[w] = (cnt[w] != '0);
        end
    end

    assign busy = (~free_mask != '0) || out_busy;

    if (OUT_REG != 0) begin : g_out_reg
        logic                   out_valid;
        logic [NW_BITS-1:0]     out_wid;
        logic [31:0]            out_pc;
        logic [NUM_THREADS-1:0] out_tmask;
        logic [31:0]            out_instr;

        assign rsp_ready_int = !out_valid || ifetch_rsp_ready;

        // Output register: loads on accepted response, holds under backpressure.
        always_ff @(posedge clk) begin
            if (reset) begin
                out_valid <= 1'b0;
                out_wid   <= '0;
                out_pc    <= '0;
                out_tmask <= '0;
                out_instr <= '0;
            end else if (rsp_take) begin
                out_valid <= 1'b1;
                out_wid   <= rd_wid;
                out_pc    <= rd_pc;
                out_tmask <= rd_tmask;
                out_instr <= icache_rsp_data;
            end else if (ifetch_rsp_ready) begin
                out_valid <= 1'b0;
            end
        end

        assign ifetch_rsp_valid = out_valid;
        assign ifetch_rsp_wid   = out_wid;
        assign ifetch_rsp_PC    = out_pc;
        assign ifetch_rsp_tmask = out_tmask;
        assign ifetch_rsp_instr = out_instr;
        assign out_busy         = out_valid;
    end else begin : g_pass
        assign rsp_ready_int    = ifetch_rsp_ready;
        assign ifetch_rsp_valid = icache_rsp_valid && rsp_hit;
        assign ifetch_rsp_wid   = rd_wid;
        assign ifetch_rsp_PC    = rd_pc;
        assign ifetch_rsp_tmask = rd_tmask;
        assign ifetch_rsp_instr = icache_rsp_data;
        assign out_busy         = 1'b0;
    end

`ifndef SYNTHESIS
    // Stale-tag and counter-underflow checks.
    always_ff @(posedge clk) begin
        if (!reset && icache_rsp_valid) begin
            assert (rsp_hit)
                else $warning("core%0d icache: stale response tag=%0d dropped", CORE_ID, icache_rsp_tag);
        end
        if (!reset && rsp_take) begin
            assert (cnt[rd_wid] != '0)
                else $error("core%0d icache: counter underflow wid=%0d", CORE_ID, rd_wid);
        end
    end
`endif

`ifdef DBG_PRINT_CORE_ICACHE
    // Request/response trace.
    always_ff @(posedge clk) begin
        if (!reset && req_fire)
            $display("%t: core%0d icache req: wid=%0d PC=%h tag=%0d", $time, CORE_ID,
                     ifetch_req_wid, ifetch_req_PC, alloc_idx);
        if (!reset && rsp_take)
            $display("%t: core%0d icache rsp: wid=%0d PC=%h tag=%0d instr=%h", $time, CORE_ID,
                     rd_wid, rd_pc, icache_rsp_tag, icache_rsp_data);
    end
`endif

endmodule

// File: tb/tb_vx_icache_stage_mo.sv
// Scoreboard bench for vx_icache_stage_mo (8 warps, 8 tags, 2 pending, OUT_REG=1).
module tb_vx_icache_stage_mo;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifetch_req_valid;
    logic [2:0]  ifetch_req_wid;
    logic [31:0] ifetch_req_PC;
    logic [3:0]  ifetch_req_tmask;
    logic        ifetch_req_ready;
    logic        icache_req_valid;
    logic [29:0] icache_req_addr;
    logic [2:0]  icache_req_tag;
    logic        icache_req_ready;
    logic        icache_rsp_valid;
    logic [31:0] icache_rsp_data;
    logic [2:0]  icache_rsp_tag;
    logic        icache_rsp_ready;
    logic        ifetch_rsp_valid;
    logic [2:0]  ifetch_rsp_wid;
    logic [31:0] ifetch_rsp_PC;
    logic [3:0]  ifetch_rsp_tmask;
    logic [31:0] ifetch_rsp_instr;
    logic        ifetch_rsp_ready;
    logic [7:0]  pending_warps;
    logic        busy;

    typedef struct packed {
        logic [2:0]  wid;
        logic [31:0] pc;
        logic [3:0]  tmask;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;

    vx_icache_stage_mo #(
        .CORE_ID(0), .NUM_WARPS(8), .NUM_THREADS(4),
        .TAG_DEPTH(8), .MAX_PENDING(2), .OUT_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .ifetch_req_valid(ifetch_req_valid), .ifetch_req_wid(ifetch_req_wid),
        .ifetch_req_PC(ifetch_req_PC), .ifetch_req_tmask(ifetch_req_tmask),
        .ifetch_req_ready(ifetch_req_ready),
        .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
        .icache_req_tag(icache_req_tag), .icache_req_ready(icache_req_ready),
        .icache_rsp_valid(icache_rsp_valid), .icache_rsp_data(icache_rsp_data),
        .icache_rsp_tag(icache_rsp_tag), .icache_rsp_ready(icache_rsp_ready),
        .ifetch_rsp_valid(ifetch_rsp_valid), .ifetch_rsp_wid(ifetch_rsp_wid),
        .ifetch_rsp_PC(ifetch_rsp_PC), .ifetch_rsp_tmask(ifetch_rsp_tmask),
        .ifetch_rsp_instr(ifetch_rsp_instr), .ifetch_rsp_ready(ifetch_rsp_ready),
        .pending_warps(pending_warps), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch that must be accepted with the given tag.
    task automatic issue(input logic [2:0] wid, input logic [31:0] pc, input logic [3:0] tm,
                         input logic [2:0] exp_tag);
        ifetch_req_valid = 1'b1;
        ifetch_req_wid   = wid;
        ifetch_req_PC    = pc;
        ifetch_req_tmask = tm;
        @(negedge clk);
        chk("req_ready", 32'(ifetch_req_ready), 32'd1);
        chk("req_tag", 32'(icache_req_tag), 32'(exp_tag));
        step();
        ifetch_req_valid = 1'b0;
    endtask

    // Return one I-cache response and record the expected decode output.
    task automatic respond(input logic [2:0] tag, input logic [31:0] data,
                           input logic [2:0] wid, input logic [31:0] pc, input logic [3:0] tm);
        q.push_back('{wid: wid, pc: pc, tmask: tm, instr: data});
        pushed++;
        icache_rsp_valid = 1'b1;
        icache_rsp_tag   = tag;
        icache_rsp_data  = data;
        @(negedge clk);
        chk("rsp_ready", 32'(icache_rsp_ready), 32'd1);
        step();
        icache_rsp_valid = 1'b0;
    endtask

    // Monitor: pop and compare on every accepted decode output.
    always @(negedge clk) begin
        if (!reset && ifetch_rsp_valid && ifetch_rsp_ready) begin
            exp_t e;
            checks++;
            popped++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got wid=%0d PC=%h instr=%h with empty scoreboard",
                         ifetch_rsp_wid, ifetch_rsp_PC, ifetch_rsp_instr);
            end else begin
                e = q.pop_front();
                if (ifetch_rsp_wid !== e.wid || ifetch_rsp_PC !== e.pc ||
                    ifetch_rsp_tmask !== e.tmask || ifetch_rsp_instr !== e.instr) begin
                    errors++;
                    $display("FAIL rsp_data: got wid=%0d PC=%h tm=%h instr=%h expected wid=%0d PC=%h tm=%h instr=%h",
                             ifetch_rsp_wid, ifetch_rsp_PC, ifetch_rsp_tmask, ifetch_rsp_instr,
                             e.wid, e.pc, e.tmask, e.instr);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b1;
        ifetch_req_valid = 1'b0;
        ifetch_req_wid   = '0;
        ifetch_req_PC    = '0;
        ifetch_req_tmask = '0;
        icache_req_ready = 1'b1;
        icache_rsp_valid = 1'b0;
        icache_rsp_data  = '0;
        icache_rsp_tag   = '0;
        ifetch_rsp_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(ifetch_rsp_valid), 32'd0);
        chk("rst_pending", 32'(pending_warps), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();

        // Single fetch.
        ifetch_req_valid = 1'b1;
        ifetch_req_wid   = 3'd1;
        ifetch_req_PC    = 32'h8000_0000;
        ifetch_req_tmask = 4'hF;
        @(negedge clk);
        chk("single_req_valid", 32'(icache_req_valid), 32'd1);
        chk("single_addr", 32'(icache_req_addr), 32'h2000_0000);
        chk("single_tag", 32'(icache_req_tag), 32'd0);
        step();
        ifetch_req_valid = 1'b0;
        @(negedge clk);
        chk("single_pending", 32'(pending_warps), 32'h02);
        chk("single_busy", 32'(busy), 32'd1);
        step();
        respond(3'd0, 32'h0000_0013, 3'd1, 32'h8000_0000, 4'hF);
        @(negedge clk);
        chk("single_pending_clr", 32'(pending_warps), 32'h00);
        step();
        @(negedge clk);
        chk("single_idle_busy", 32'(busy), 32'd0);
        step();

        // Per-warp limit: third fetch of warp 0 stalls until tag 0 returns.
        issue(3'd0, 32'h0000_1000, 4'hF, 3'd0);
        issue(3'd0, 32'h0000_1004, 4'hF, 3'd1);
        ifetch_req_valid = 1'b1;
        ifetch_req_wid   = 3'd0;
        ifetch_req_PC    = 32'h0000_1008;
        ifetch_req_tmask = 4'hF;
        q.push_back('{wid: 3'd0, pc: 32'h0000_1000, tmask: 4'hF, instr: 32'h0000_00A0});
        pushed++;
        icache_rsp_valid = 1'b1;
        icache_rsp_tag   = 3'd0;
        icache_rsp_data  = 32'h0000_00A0;
        @(negedge clk);
        chk("limit_ready", 32'(ifetch_req_ready), 32'd0);
        chk("limit_req_valid", 32'(icache_req_valid), 32'd0);
        chk("limit_rsp_ready", 32'(icache_rsp_ready), 32'd1);
        step();
        icache_rsp_valid = 1'b0;
        @(negedge clk);
        chk("limit_reissue_ready", 32'(ifetch_req_ready), 32'd1);
        chk("limit_reissue_tag", 32'(icache_req_tag), 32'd0);
        step();
        ifetch_req_valid = 1'b0;
        respond(3'd1, 32'h0000_00A1, 3'd0, 32'h0000_1004, 4'hF);
        respond(3'd0, 32'h0000_00A2, 3'd0, 32'h0000_1008, 4'hF);
        step();

        // Out-of-order return.
        issue(3'd0, 32'h0000_0100, 4'hF, 3'd0);
        issue(3'd1, 32'h0000_0200, 4'hF, 3'd1);
        issue(3'd2, 32'h0000_0300, 4'hF, 3'd2);
        issue(3'd3, 32'h0000_0400, 4'hF, 3'd3);
        @(negedge clk);
        chk("ooo_pending", 32'(pending_warps), 32'h0F);
        step();
        respond(3'd2, 32'h0030_0013, 3'd2, 32'h0000_0300, 4'hF);
        respond(3'd0, 32'h0010_0013, 3'd0, 32'h0000_0100, 4'hF);
        respond(3'd3, 32'h0040_0013, 3'd3, 32'h0000_0400, 4'hF);
        respond(3'd1, 32'h0020_0013, 3'd1, 32'h0000_0200, 4'hF);
        step();

        // Fill the table: one fetch per warp, PC 0x2000+16*w, tmask w+1.
        for (int w = 0; w < 8; w++) begin
            issue(3'(w), 32'(32'h2000 + 16 * w), 4'(w + 1), 3'(w));
        end

        // Same-cycle alloc/free: table full, tag 5 returns while a request waits.
        ifetch_req_valid = 1'b1;
        ifetch_req_wid   = 3'd0;
        ifetch_req_PC    = 32'h0000_0900;
        ifetch_req_tmask = 4'hA;
        q.push_back('{wid: 3'd5, pc: 32'h0000_2050, tmask: 4'h6, instr: 32'h0000_00D5});
        pushed++;
        icache_rsp_valid = 1'b1;
        icache_rsp_tag   = 3'd5;
        icache_rsp_data  = 32'h0000_00D5;
        @(negedge clk);
        chk("full_req_valid", 32'(icache_req_valid), 32'd0);
        chk("full_req_ready", 32'(ifetch_req_ready), 32'd0);
        chk("full_rsp_ready", 32'(icache_rsp_ready), 32'd1);
        step();
        icache_rsp_valid = 1'b0;
        @(negedge clk);
        chk("reuse_ready", 32'(ifetch_req_ready), 32'd1);
        chk("reuse_tag", 32'(icache_req_tag), 32'd5);
        chk("reuse_busy", 32'(busy), 32'd1);
        step();
        ifetch_req_valid = 1'b0;

        // Backpressure: hold decode for 3 cycles with a second response waiting.
        ifetch_rsp_ready = 1'b0;
        q.push_back('{wid: 3'd0, pc: 32'h0000_2000, tmask: 4'h1, instr: 32'h0000_00D0});
        pushed++;
        icache_rsp_valid = 1'b1;
        icache_rsp_tag   = 3'd0;
        icache_rsp_data  = 32'h0000_00D0;
        @(negedge clk);
        chk("bp_first_ready", 32'(icache_rsp_ready), 32'd1);
        step();
        q.push_back('{wid: 3'd1, pc: 32'h0000_2010, tmask: 4'h2, instr: 32'h0000_00D1});
        pushed++;
        icache_rsp_tag  = 3'd1;
        icache_rsp_data = 32'h0000_00D1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(ifetch_rsp_valid), 32'd1);
            chk("bp_out_pc", ifetch_rsp_PC, 32'h0000_2000);
            chk("bp_out_instr", ifetch_rsp_instr, 32'h0000_00D0);
            chk("bp_rsp_ready", 32'(icache_rsp_ready), 32'd0);
            step();
        end
        ifetch_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(icache_rsp_ready), 32'd1);
        step();
        icache_rsp_valid = 1'b0;

        // Drain at one per cycle; the previous response is visible each cycle.
        begin
            logic [2:0]  dtag [7];
            logic [2:0]  dwid [7];
            logic [31:0] dpc  [7];
            logic [3:0]  dtm  [7];
            dtag = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd5, 3'd0};
            dwid = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd0, 3'd0};
            dpc  = '{32'h2020, 32'h2030, 32'h2040, 32'h2060, 32'h2070, 32'h0900, 32'h0};
            dtm  = '{4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hA, 4'h0};
            for (int i = 0; i < 6; i++) begin
                q.push_back('{wid: dwid[i], pc: dpc[i], tmask: dtm[i], instr: 32'(32'hE0 + i)});
                pushed++;
                icache_rsp_valid = 1'b1;
                icache_rsp_tag   = dtag[i];
                icache_rsp_data  = 32'(32'hE0 + i);
                @(negedge clk);
                chk("drain_out_valid", 32'(ifetch_rsp_valid), 32'd1);
                chk("drain_rsp_ready", 32'(icache_rsp_ready), 32'd1);
                step();
            end
        end
        icache_rsp_valid = 1'b0;
        step();
        @(negedge clk);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_pending", 32'(pending_warps), 32'h00);
        step();

        // Reset mid-flight, then a stale response on tag 1.
        issue(3'd1, 32'h0000_3000, 4'hF, 3'd0);
        issue(3'd2, 32'h0000_3004, 4'hF, 3'd1);
        issue(3'd3, 32'h0000_3008, 4'hF, 3'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_pending", 32'(pending_warps), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(ifetch_rsp_valid), 32'd0);
        step();
        icache_rsp_valid = 1'b1;
        icache_rsp_tag   = 3'd1;
        icache_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stale_rsp_ready", 32'(icache_rsp_ready), 32'd1);
        step();
        icache_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stale_no_output", 32'(ifetch_rsp_valid), 32'd0);
        chk("stale_busy", 32'(busy), 32'd0);
        step();

        chk("sb_empty", 32'(q.size()), 32'd0);
        chk("sb_count", 32'(popped), 32'(pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
